// File: rtl/igs027a_bus_arb.sv
// Mailbox bus arbiter for the IGS027A protection core: shares the register file between the
// 68k bus cycle and the HPS debug port, one access in flight, with a forced-completion timeout.
module igs027a_bus_arb #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TO_W    = 7
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m68k_cs,
    input  logic        m68k_rw,
    input  logic [3:0]  m68k_addr,
    input  logic [15:0] m68k_din,
    output logic [15:0] m68k_dout,
    output logic        m68k_dtack_n,

    input  logic        hps_req,
    input  logic        hps_rw,
    input  logic [3:0]  hps_addr,
    input  logic [15:0] hps_din,
    output logic [15:0] hps_rdata,
    output logic        hps_ack,

    output logic [3:0]  prot_addr,
    output logic [15:0] prot_din,
    output logic        prot_we,
    output logic        prot_re,
    input  logic [15:0] prot_dout,
    input  logic        prot_dtack_n,

    output logic        timeout_err
);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StHold} state_e;

    state_e          state_q;
    logic            pend_hps_q;
    logic            last_hps_q;
    logic            grant_hps_q;
    logic            cur_rw_q;
    logic            hold_rw_q;
    logic [3:0]      hold_addr_q;
    logic [15:0]     hold_din_q;
    logic [TO_W-1:0] to_cnt_q;
    logic            m68k_served_q;

    logic        m68k_pend;
    logic        pick_68k;
    logic        core_done;
    logic        timed_out;
    logic [15:0] ret_data;

    always_comb begin
        m68k_pend = m68k_cs && !m68k_served_q;
        // Round robin on a tie: the requester that did not win last time goes first.
        pick_68k  = m68k_pend && (!pend_hps_q || last_hps_q);
        core_done = !prot_dtack_n;
        timed_out = (to_cnt_q == TO_W'(TIMEOUT - 1));
        ret_data  = core_done ? prot_dout : 16'hFFFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            pend_hps_q    <= 1'b0;
            last_hps_q    <= 1'b1;
            grant_hps_q   <= 1'b0;
            cur_rw_q      <= 1'b0;
            hold_rw_q     <= 1'b0;
            hold_addr_q   <= '0;
            hold_din_q    <= '0;
            to_cnt_q      <= '0;
            m68k_served_q <= 1'b0;
            m68k_dtack_n  <= 1'b1;
            m68k_dout     <= '0;
            hps_ack       <= 1'b0;
            hps_rdata     <= '0;
            prot_addr     <= '0;
            prot_din      <= '0;
            prot_we       <= 1'b0;
            prot_re       <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            prot_we <= 1'b0;
            prot_re <= 1'b0;
            hps_ack <= 1'b0;

            if (!m68k_cs) begin
                m68k_served_q <= 1'b0;
            end

            // The pending flag stays set until the HPS access completes, so this also drops
            // pulses that arrive while an HPS access is in flight.
            if (hps_req && !pend_hps_q) begin
                pend_hps_q  <= 1'b1;
                hold_rw_q   <= hps_rw;
                hold_addr_q <= hps_addr;
                hold_din_q  <= hps_din;
            end

            case (state_q)
                StIdle: begin
                    if (m68k_pend || pend_hps_q) begin
                        grant_hps_q <= !pick_68k;
                        last_hps_q  <= !pick_68k;
                        if (pick_68k) begin
                            cur_rw_q  <= m68k_rw;
                            prot_addr <= m68k_addr;
                            prot_din  <= m68k_din;
                        end else begin
                            cur_rw_q  <= hold_rw_q;
                            prot_addr <= hold_addr_q;
                            prot_din  <= hold_din_q;
                        end
                        state_q <= StIssue;
                    end
                end

                StIssue: begin
                    prot_re  <= cur_rw_q;
                    prot_we  <= !cur_rw_q;
                    to_cnt_q <= '0;
                    state_q  <= StWait;
                end

                StWait: begin
                    if (core_done || timed_out) begin
                        if (!core_done) begin
                            timeout_err <= 1'b1;
                        end
                        if (grant_hps_q) begin
                            hps_ack <= 1'b1;
                            if (cur_rw_q) begin
                                hps_rdata <= ret_data;
                            end
                        end else begin
                            m68k_dtack_n  <= 1'b0;
                            m68k_served_q <= 1'b1;
                            if (cur_rw_q) begin
                                m68k_dout <= ret_data;
                            end
                        end
                        state_q <= StResp;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end

                StResp: begin
                    if (grant_hps_q) begin
                        pend_hps_q <= 1'b0;
                        state_q    <= StIdle;
                    end else if (!m68k_cs) begin
                        m68k_dtack_n <= 1'b1;
                        state_q      <= StIdle;
                    end else begin
                        state_q <= StHold;
                    end
                end

                StHold: begin
                    if (!m68k_cs) begin
                        m68k_dtack_n <= 1'b1;
                        state_q      <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/igs027a_bus_arb.md
Name: igs027a_bus_arb

Overview:
- Arbitrates the IGS027A protection mailbox register file between two requesters:
  - the 68k main CPU bus cycle (level-held chip select, DTACK handshake);
  - the MiSTer HPS/debug port (pulse request, pulse acknowledge).
- Turns each granted access into a single-cycle we/re strobe toward the protection HLE core and waits for that core's dtack_n.
- Returns read data to the winning requester, or forces a timeout completion if the core never responds.
- Sits between the PGM 68k address decoder / HPS bridge and the protection core.

Parameters:
- TIMEOUT, 64: cycles spent in WAIT without prot_dtack_n low before a forced completion.
- TO_W, 7: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m68k_cs  in  1  68k access to the protection window; held high until the bus cycle ends
- m68k_rw  in  1  1 = read, 0 = write
- m68k_addr  in  4  register index (68k adr[4:1])
- m68k_din  in  16  write data
- m68k_dout  out  16  read data to the 68k
- m68k_dtack_n  out  1  active-low DTACK to the 68k
- hps_req  in  1  single-cycle request pulse
- hps_rw  in  1  1 = read, 0 = write; sampled with hps_req
- hps_addr  in  4  register index; sampled with hps_req
- hps_din  in  16  write data; sampled with hps_req
- hps_rdata  out  16  read data; valid while hps_ack is high
- hps_ack  out  1  single-cycle completion pulse
- prot_addr  out  4  to the core
- prot_din  out  16  to the core
- prot_we  out  1  single-cycle write strobe
- prot_re  out  1  single-cycle read strobe
- prot_dout  in  16  core read data
- prot_dtack_n  in  1  core completion, active low
- timeout_err  out  1  sticky; set on any timeout

Behaviour:
- Reset values:
  - m68k_dtack_n = 1, hps_ack = 0, prot_we = 0, prot_re = 0, timeout_err = 0.
  - m68k_dout, hps_rdata, prot_addr, prot_din = 0.
  - State = IDLE, HPS pending flag cleared, last_grant = HPS.
- Reset mid-operation: aborts immediately.
  - No strobe and no ack/dtack are produced for the aborted access.
  - A 68k cs still high after reset is treated as a new request.
- HPS request latching:
  - hps_req sets pend_hps and captures rw/addr/din into a holding register.
  - A pulse that arrives while pend_hps is set, or while an HPS access is in flight, is dropped.
- 68k pending condition: m68k_cs high AND m68k_served = 0.
  - m68k_served is set when DTACK is given and cleared when m68k_cs is sampled low.
- IDLE:
  - Only one requester pending: grant it.
  - Both pending: grant the requester that is NOT last_grant (round robin). Reset value of last_grant means the 68k wins the first tie.
  - On a grant: register addr/din onto prot_addr/prot_din, update last_grant, go to ISSUE.
- ISSUE (1 cycle):
  - Exactly one of prot_we/prot_re is high, for this cycle only.
  - prot_addr/prot_din stay stable from ISSUE until the state leaves WAIT.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - prot_dtack_n sampled low: capture prot_dout (reads only) into the grantee's read register; go to RESP.
  - Counter reaches TIMEOUT-1 with no dtack:
    - return data = 16'hFFFF for reads (write data is discarded);
    - set timeout_err;
    - go to RESP.
- RESP:
  - 68k grant: drive m68k_dtack_n = 0 with m68k_dout stable; set m68k_served; go to HOLD.
  - HPS grant: hps_ack = 1 for one cycle with hps_rdata valid; clear pend_hps; go to IDLE.
- HOLD:
  - Keep m68k_dtack_n low and m68k_dout stable until m68k_cs is sampled low.
  - Then m68k_dtack_n = 1 on the next edge; go to IDLE.
  - An HPS request arriving during HOLD stays pending; it is served after HOLD.
- Latency, with a core that responds one cycle after the strobe:
  - request sampled in IDLE at edge N;
  - strobe high after edge N+1;
  - dtack_n from the core low after edge N+2;
  - m68k_dtack_n / hps_ack asserted after edge N+3.
- Strobe spacing: at most one access is in flight, so strobes are at least 3 cycles apart.
- Other rules:
  - An HPS write never alters m68k_dout, and vice versa.
  - timeout_err is cleared only by reset.

Test Plan:
- 68k read, addr 0: core returns 16'h0001 one cycle after prot_re. Required: prot_re is a single pulse with prot_addr=0; m68k_dtack_n goes low 3 cycles after cs is sampled with m68k_dout=16'h0001; dtack_n stays low until cs drops, then returns high on the next edge.
- HPS write, addr 1, 16'h1234. Required: a single prot_we pulse with prot_din=16'h1234; hps_ack pulses for exactly 1 cycle; m68k_dtack_n stays high throughout.
- Simultaneous 68k read and HPS read, from reset. Required: the 68k is served first, the HPS second. Repeat the simultaneous requests: the HPS is served first, the 68k second (round robin).
- Core never asserts dtack, TIMEOUT=64. Required: after 64 WAIT cycles the 68k gets DTACK with m68k_dout=16'hFFFF and timeout_err=1; a following normal access still works and timeout_err stays 1.
- 68k holds cs high for 20 cycles after DTACK. Required: exactly one prot strobe is issued; a pending HPS request is granted only after cs falls.
- Reset asserted during WAIT with the 68k granted. Required: no DTACK is given and all outputs take their reset values; cs still high after reset produces a fresh access with one strobe.
